// File: rtl/hvc_supply_seq.sv
// HVC pad-domain power sequencer: debounces pad power-good, then orders clamp and core-switch enables.
// Optional macro HVC_SEQ_FAULT_LATCH_EN latches brown-outs in a FAULT state until CLR_FAULT.
module hvc_supply_seq #(
  parameter int DEB_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       PWRGOOD_PAD,
  input  logic       CLR_FAULT,
  output logic       CLAMP_EN,
  output logic       CORE_SW_EN,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [7:0] BROWNOUT_CNT
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_RAMP     = 3'd2,
    S_READY    = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic             pg_meta_p0;
  logic             pg_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             brownout;

  // Stage p0/p1: two-flop synchronizer for the asynchronous pad power-good
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pg_meta_p0 <= 1'b0;
      pg_s       <= 1'b0;
    end else begin
      pg_meta_p0 <= PWRGOOD_PAD;
      pg_s       <= pg_meta_p0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    brownout = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (ENABLE && pg_s) state_d = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!pg_s || !ENABLE)     state_d = S_OFF;
        else if (cnt_q == DEB_LAST) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (!pg_s)                     brownout = 1'b1;
        else if (!ENABLE)              state_d  = S_SHUTDOWN;
        else if (cnt_q == SETTLE_LAST) state_d  = S_READY;
      end
      S_READY: begin
        cnt_d = '0;
        if (!pg_s)        brownout = 1'b1;
        else if (!ENABLE) state_d  = S_SHUTDOWN;
      end
      S_SHUTDOWN: begin
        if (cnt_q == SETTLE_LAST) state_d = S_OFF;
      end
      S_FAULT: begin
        cnt_d = '0;
`ifdef HVC_SEQ_FAULT_LATCH_EN
        if (CLR_FAULT) state_d = S_OFF;
`else
        state_d = S_OFF;
`endif
      end
      default: begin
        cnt_d   = '0;
        state_d = S_OFF;
      end
    endcase
    if (brownout) begin
`ifdef HVC_SEQ_FAULT_LATCH_EN
      state_d = S_FAULT;
`else
      state_d = S_OFF;
`endif
    end
    // Counter restarts on every transition so each state times from zero
    if (state_d != state_q) cnt_d = '0;
  end

  // Stage p2: state and Moore outputs registered from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      CLAMP_EN     <= 1'b0;
      CORE_SW_EN   <= 1'b0;
      READY        <= 1'b0;
      BROWNOUT_CNT <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      CLAMP_EN   <= (state_d == S_RAMP) || (state_d == S_READY) || (state_d == S_SHUTDOWN);
      CORE_SW_EN <= (state_d == S_READY);
      READY      <= (state_d == S_READY);
      if (brownout && (BROWNOUT_CNT != 8'hFF)) BROWNOUT_CNT <= BROWNOUT_CNT + 8'd1;
    end
  end

  assign STATE = state_q;

`ifdef HVC_SEQ_FAULT_LATCH_EN
  logic fault_q;

  always_ff @(posedge CLK) begin
    if (RESET) fault_q <= 1'b0;
    else       fault_q <= (state_d == S_FAULT);
  end

  assign FAULT = fault_q;
`else
  logic unused_clr_fault;

  assign unused_clr_fault = CLR_FAULT;
  assign FAULT            = 1'b0;
`endif

endmodule
